// File: rtl/mmcm_ps_ctrl.sv
// MMCM fine phase-shift sequencer: steps psen/psincdec toward an absolute
// target along the shortest modular path, tracking phase and errors.
module mmcm_ps_ctrl #(
  parameter int PHASE_W   = 12,
  parameter int PS_PERIOD = 1120,
  parameter int TIMEOUT   = 255,
  parameter int GAP_CYC   = 2
) (
  input  logic               psclk,
  input  logic               reset,
  input  logic               locked,
  input  logic               psdone,
  output logic               psen,
  output logic               psincdec,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [PHASE_W-1:0] cmd_target,
  output logic [PHASE_W-1:0] cur_phase,
  output logic               busy,
  output logic               done,
  output logic               err_range,
  output logic               err_timeout,
  output logic               err_abort
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam int GW = $clog2(GAP_CYC + 1);

  localparam logic [PHASE_W:0]   P_FULL = (PHASE_W+1)'(PS_PERIOD);
  localparam logic [PHASE_W-1:0] P_N    = PHASE_W'(PS_PERIOD);
  localparam logic [PHASE_W-1:0] P_LAST = PHASE_W'(PS_PERIOD - 1);
  localparam logic [PHASE_W-1:0] P_HALF = PHASE_W'(PS_PERIOD / 2);
  localparam logic [CW-1:0]      T_LAST = CW'(TIMEOUT - 1);
  localparam logic [GW-1:0]      G_LAST = GW'(GAP_CYC - 1);

  typedef enum logic [2:0] {
    S_UNLOCKED,
    S_IDLE,
    S_PULSE,
    S_WAIT,
    S_GAP
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic [PHASE_W-1:0] r_phase;
  logic [PHASE_W-1:0] r_rem;
  logic [CW-1:0]      r_wait;
  logic [GW-1:0]      r_gap;
  logic               r_inc;
  logic               r_done;
  logic               r_err_range;
  logic               r_err_to;
  logic               r_err_ab;

  logic               w_accept;
  logic               w_inrange;
  logic [PHASE_W:0]   w_diff_x;
  logic [PHASE_W-1:0] w_diff;
  logic               w_dir_inc;
  logic [PHASE_W-1:0] w_steps;
  logic [PHASE_W-1:0] w_phase_step;
  logic               w_busy;

  assign cmd_ready   = (r_state == S_IDLE);
  assign psen        = (r_state == S_PULSE);
  assign w_busy      = (r_state == S_PULSE) ||
                       (r_state == S_WAIT)  ||
                       (r_state == S_GAP);
  assign busy        = w_busy;
  assign psincdec    = r_inc;
  assign cur_phase   = r_phase;
  assign done        = r_done;
  assign err_range   = r_err_range;
  assign err_timeout = r_err_to;
  assign err_abort   = r_err_ab;

  assign w_accept  = cmd_valid & cmd_ready;
  assign w_inrange = ({1'b0, cmd_target} < P_FULL);

  // Both operands are below PS_PERIOD, so one wrap-add gives the modulo.
  always_comb begin
    w_diff_x = '0;
    if (cmd_target >= r_phase)
      w_diff_x = {1'b0, cmd_target} - {1'b0, r_phase};
    else
      w_diff_x = {1'b0, cmd_target} + P_FULL - {1'b0, r_phase};
  end

  assign w_diff    = w_diff_x[PHASE_W-1:0];
  assign w_dir_inc = (w_diff <= P_HALF);
  assign w_steps   = w_dir_inc ? w_diff : (P_N - w_diff);

  always_comb begin
    w_phase_step = r_phase;
    if (r_inc)
      w_phase_step = (r_phase == P_LAST) ? '0 : r_phase + 1'b1;
    else
      w_phase_step = (r_phase == '0) ? P_LAST : r_phase - 1'b1;
  end

  always_ff @(posedge psclk) begin
    if (reset) r_state <= S_UNLOCKED;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (!locked) begin
      w_next = S_UNLOCKED;
    end else begin
      unique case (r_state)
        S_UNLOCKED: w_next = S_IDLE;
        S_IDLE:
          if (w_accept && w_inrange && (w_diff != '0))
            w_next = S_PULSE;
        S_PULSE: w_next = S_WAIT;
        S_WAIT:
          if (psdone)
            w_next = (r_rem == 1) ? S_IDLE : S_GAP;
          else if (r_wait >= T_LAST)
            w_next = S_IDLE;
        S_GAP:
          if (r_gap >= G_LAST)
            w_next = S_PULSE;
        default: w_next = S_UNLOCKED;
      endcase
    end
  end

  always_ff @(posedge psclk) begin
    if (reset) begin
      r_phase     <= '0;
      r_rem       <= '0;
      r_wait      <= '0;
      r_gap       <= '0;
      r_inc       <= 1'b0;
      r_done      <= 1'b0;
      r_err_range <= 1'b0;
      r_err_to    <= 1'b0;
      r_err_ab    <= 1'b0;
    end else begin
      r_done      <= 1'b0;
      r_err_range <= 1'b0;
      if (!locked) begin
        // The MMCM restarts at phase zero after relocking.
        r_phase <= '0;
        r_rem   <= '0;
        if (w_busy) r_err_ab <= 1'b1;
      end else begin
        unique case (r_state)
          S_IDLE:
            if (w_accept) begin
              r_err_to <= 1'b0;
              r_err_ab <= 1'b0;
              if (!w_inrange) begin
                r_err_range <= 1'b1;
              end else if (w_diff == '0) begin
                r_done <= 1'b1;
              end else begin
                r_rem <= w_steps;
                r_inc <= w_dir_inc;
              end
            end
          S_PULSE: r_wait <= CW'(1);
          S_WAIT:
            if (psdone) begin
              r_phase <= w_phase_step;
              r_rem   <= r_rem - 1'b1;
              r_gap   <= '0;
              if (r_rem == 1) r_done <= 1'b1;
            end else if (r_wait >= T_LAST) begin
              r_err_to <= 1'b1;
              r_rem    <= '0;
            end else begin
              r_wait <= r_wait + 1'b1;
            end
          S_GAP: r_gap <= r_gap + 1'b1;
          default: ;
        endcase
      end
    end
  end

endmodule
